// File: rtl/bit_collector_pkg.sv
// bit_collector_pkg
//   Definitions shared by the serial bit collector and the downstream
//   population-count stage.
//
//   Contents:
//     ST_FILL / ST_FULL : collector state encodings.
//     pos_w()           : width of a 0..DATA_W fill level or count value.
//
//   Ports: none (package).
package bit_collector_pkg;

  localparam logic [0:0] ST_FILL = 1'b0;  // collecting bits of a partial word
  localparam logic [0:0] ST_FULL = 1'b1;  // holding a complete word

  // Wide enough to hold every value from 0 up to and including data_w.
  function automatic int pos_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bit_collector.sv
// bit_collector
//   Serial-to-parallel collector feeding the population-count stage. One bit
//   is taken per in_valid/in_ready handshake and packed LSB first into a
//   DATA_W-bit word. A completed word is held on out_data/out_valid until
//   out_ready consumes it.
//
//   Ports:
//     clk        : clock, rising-edge active
//     rst        : asynchronous active-high reset
//     in_bit     : serial data bit
//     in_valid   : in_bit is valid this cycle
//     in_ready   : collector accepts a bit this cycle
//     flush      : synchronous discard of the partial word (ignored when full)
//     out_data   : assembled word, first accepted bit at bit 0
//     out_valid  : out_data holds a complete word
//     out_ready  : consumer takes out_data this cycle
//     fill_level : bits held in the partial word, DATA_W when full
//     out_sum    : number of ones in out_data (BIT_COLLECTOR_POPCNT_EN only)
//
//   Build option:
//     BIT_COLLECTOR_POPCNT_EN : adds out_sum, maintained incrementally as bits
//                               arrive so the count is registered alongside
//                               the word.
module bit_collector
  import bit_collector_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int POS_W  = pos_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef BIT_COLLECTOR_POPCNT_EN
  output logic [POS_W-1:0]  out_sum,
`endif
  output logic [POS_W-1:0]  fill_level
);

  logic [0:0]        state_q, state_d;
  logic [POS_W-1:0]  fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [POS_W-1:0]  sum_q, sum_d;
  logic              in_acc_s;
  logic              out_acc_s;
  logic [POS_W-1:0]  fill_inc_s;

  // A full word frees its slot in the same cycle it is consumed, so the
  // upstream handshake looks straight through to out_ready.
  assign in_ready   = (state_q == ST_FILL) | out_ready;
  assign in_acc_s   = in_valid & in_ready;
  assign out_acc_s  = (state_q == ST_FULL) & out_ready;
  assign fill_inc_s = fill_q + POS_W'(1);

  // Next-state computation for the fill position, word and running count.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    data_d  = data_q;
    sum_d   = sum_q;
    case (state_q)
      ST_FILL: begin
        if (flush) begin
          fill_d = '0;
          data_d = '0;
          sum_d  = '0;
        end else if (in_acc_s) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (fill_q == POS_W'(i)) begin
              data_d[i] = in_bit;
            end else begin
              data_d[i] = data_q[i];
            end
          end
          fill_d = fill_inc_s;
          sum_d  = sum_q + POS_W'(in_bit);
          if (fill_inc_s == POS_W'(DATA_W)) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FULL: begin
        // A held word is never discarded by flush; flush only suppresses
        // the bit that would start the next word.
        if (out_acc_s) begin
          if (in_acc_s && !flush) begin
            data_d    = '0;
            data_d[0] = in_bit;
            fill_d    = POS_W'(1);
            sum_d     = POS_W'(in_bit);
            // A one-bit word is complete as soon as its bit arrives.
            state_d   = (DATA_W == 1) ? ST_FULL : ST_FILL;
          end else begin
            data_d  = '0;
            fill_d  = '0;
            sum_d   = '0;
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_FILL;
        fill_d  = '0;
        data_d  = '0;
        sum_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = (state_q == ST_FULL);
  assign fill_level = fill_q;

`ifdef BIT_COLLECTOR_POPCNT_EN
  assign out_sum = sum_q;
`else
  // Without the count port the running sum has no consumer; it is kept so
  // the datapath is identical in both builds and is trimmed by synthesis.
  logic unused_sum_s;
  assign unused_sum_s = ^sum_q;
`endif

endmodule

// File: doc/bit_collector.md
Name: bit_collector

Overview:
- Serial-to-parallel collector that sits directly upstream of the population-count stage.
- Accepts one bit per handshake and packs DATA_W bits into a word, LSB first.
- Presents each completed word on a valid/ready output port and holds it until it is consumed.
- The output word is the operand the downstream popcount stage sums.

Parameters:
- DATA_W, 10, number of bits per assembled word (>=1).
- POS_W, $clog2(DATA_W+1), width of the fill level and of the optional count output.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  collector can accept a bit this cycle.
- flush  in  1  synchronous; discards the partial word.
- out_data  out  DATA_W  assembled word; first accepted bit is at bit 0.
- out_valid  out  1  out_data holds a complete word.
- out_ready  in  1  consumer accepts out_data this cycle.
- fill_level  out  POS_W  bits currently held in the partial word (0..DATA_W-1; DATA_W when full).

Behaviour:
- Reset, applied asynchronously: state=FILL, fill_level=0, out_data=0, out_valid=0. in_ready is 1 once rst is released.
- States:
  - FILL: collecting bits; out_valid=0.
  - FULL: holding a complete word; out_valid=1, fill_level=DATA_W.
- Input accept: in_valid&in_ready at an edge.
  - The bit is written to out_data[fill_level].
  - fill_level increments.
- FILL -> FULL: on the accept that makes fill_level reach DATA_W.
  - out_valid rises on the cycle after the edge on which the last bit is accepted (latency 1 from the last bit).
- in_ready = (state==FILL) | out_ready. The in_ready->out_ready path is combinational; there is no combinational path from in_valid to any output.
- Output accept: out_valid&out_ready at an edge.
  - If there is no simultaneous input accept: go to FILL, fill_level=0.
  - If there is a simultaneous input accept: the new bit becomes bit 0 of the next word, fill_level=1, state FILL. With DATA_W=1 the state stays FULL with the new word.
- out_data: bits at index >= fill_level are don't-care while in FILL.
  - Implementation clears the word on output accept and on flush so they read 0; the bench checks only full words.
- In FULL without out_ready: out_data and fill_level are stable; in_ready=0; in_valid is ignored.
- flush: has priority over an input accept in the same cycle; the input bit is dropped, and in_ready is still driven as above.
  - In FILL: fill_level->0, out_data->0.
  - In FULL: no effect; a complete word is never discarded. An output accept in the same cycle behaves as the no-input-accept case.
- Reset mid-word or mid-hold: all state is lost immediately, with no output transaction.

Optional Feature:
- Macro: BIT_COLLECTOR_POPCNT_EN.
- Defined:
  - Adds output port out_sum [POS_W] = number of 1s in out_data, valid whenever out_valid=1.
  - Computed incrementally: a counter adds in_bit on each accept and clears like fill_level; reset value 0.
  - Holds with out_data while in FULL.
- Undefined: the port and the counter are absent; the downstream stage computes the count combinationally.

Decomposition:
- Shared package:
  - the state enum (FILL, FULL);
  - the POS_W width function ($clog2(DATA_W+1)), shared with the popcount stage.
- No sub-module is required. The optional count logic stays inline and must not instantiate the popcount stage, to keep the path registered.

Test Plan:
- Reset then 10 accepted bits 1,0,1,1,0,0,0,0,0,1 with out_ready=0 -> out_valid=1 one cycle after the 10th accept; out_data=10'b1000001101; in_ready=0; fill_level=10.
- Hold 5 cycles in FULL with in_valid=1 and random in_bit -> out_data unchanged; no bits absorbed.
- FULL, out_ready=1 and in_valid=1, in_bit=1 in the same cycle -> word consumed; next cycle fill_level=1, out_valid=0, out_data[0]=1.
- 4 bits accepted, then flush=1 together with in_valid=1 -> fill_level=0; bit dropped; next 10 accepted bits form a clean word.
- Async rst asserted mid-word (fill_level=6) between clock edges -> fill_level=0, out_valid=0 immediately, without waiting for a clock edge.
- With BIT_COLLECTOR_POPCNT_EN, word 10'b1111111111 -> out_sum=10; then word 0 -> out_sum=0; DATA_W=1 build: every accept yields a word and out_sum equals the bit.
